// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: write-port, long-latency, decode-hazard and register-file signals of the scheduler
interface wb_port_scheduler_if #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
);
    logic              pipe_we;
    logic [REG_AW-1:0] pipe_waddr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_hold;
    logic              ll_issue;
    logic [REG_AW-1:0] ll_issue_addr;
    logic              ll_valid;
    logic [REG_AW-1:0] ll_waddr;
    logic [DATA_W-1:0] ll_wdata;
    logic              ll_ready;
    logic [REG_AW-1:0] id_raddr1;
    logic              id_re1;
    logic [REG_AW-1:0] id_raddr2;
    logic              id_re2;
    logic [REG_AW-1:0] id_waddr;
    logic              id_we;
    logic              id_stall;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, ll_issue, ll_issue_addr, ll_valid, ll_waddr, ll_wdata,
               id_raddr1, id_re1, id_raddr2, id_re2, id_waddr, id_we,
        input  pipe_hold, ll_ready, id_stall, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, ll_issue, ll_issue_addr, ll_valid, ll_waddr, ll_wdata,
               id_raddr1, id_re1, id_raddr2, id_re2, id_waddr, id_we,
        output pipe_hold, ll_ready, id_stall, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: arbitrates the register-file write port between pipeline and long-latency unit, tracks pending destinations
module wb_port_scheduler #(
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic              clk,
    input logic              rst,
    wb_port_scheduler_if.slave bus
);
    localparam logic [REG_NUM-1:0] ONE = {{(REG_NUM-1){1'b0}}, 1'b1};
    logic [REG_NUM-1:0] pending, pend_eff, set_mask, clr_mask;
    logic [3:0]         wait_cnt;
    logic               hold_q, ll_grant, pipe_grant;
    always_comb begin
        bus.ll_ready  = ~rst & (hold_q | ~bus.pipe_we);
        ll_grant      = bus.ll_valid & bus.ll_ready;
        pipe_grant    = ~rst & bus.pipe_we & ~hold_q;
        bus.rf_we     = pipe_grant | ll_grant;
        bus.rf_waddr  = pipe_grant ? bus.pipe_waddr : ll_grant ? bus.ll_waddr : '0;
        bus.rf_wdata  = pipe_grant ? bus.pipe_wdata : ll_grant ? bus.ll_wdata : '0;
        bus.pipe_hold = hold_q;
        set_mask      = (bus.ll_issue && bus.ll_issue_addr != '0) ? ONE << bus.ll_issue_addr : '0;
        clr_mask      = ll_grant ? ONE << bus.ll_waddr : '0;
        pend_eff      = pending & ~clr_mask & ~ONE;
        bus.id_stall  = ~rst & ((bus.id_re1 & pend_eff[bus.id_raddr1]) |
                                (bus.id_re2 & pend_eff[bus.id_raddr2]) |
                                (bus.id_we  & pend_eff[bus.id_waddr]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            wait_cnt <= '0;
            hold_q   <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_mask) | set_mask;
            wait_cnt <= ll_grant || !bus.ll_valid ? 4'd0 :
                        wait_cnt == 4'(MAX_WAIT) ? wait_cnt : wait_cnt + 4'd1;
            hold_q   <= !ll_grant && bus.ll_valid && wait_cnt == 4'(MAX_WAIT - 1);
        end
    end
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed tests of grant, scoreboard, stall and starvation behaviour
module tb_wb_port_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    wb_port_scheduler_if #(.REG_AW(5), .DATA_W(32)) bus ();
    wb_port_scheduler #(.REG_NUM(32), .REG_AW(5), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic idle();
        bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0;
        bus.ll_issue = 0; bus.ll_issue_addr = 0;
        bus.ll_valid = 0; bus.ll_waddr = 0; bus.ll_wdata = 0;
        bus.id_raddr1 = 0; bus.id_re1 = 0; bus.id_raddr2 = 0; bus.id_re2 = 0;
        bus.id_waddr = 0; bus.id_we = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        bus.pipe_we = 1; bus.ll_valid = 1; bus.id_re1 = 1; bus.id_raddr1 = 4;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        tests++; if (dut.pending !== 32'h0) begin fails++; $display("FAIL reset_pending: got %h want 0", dut.pending); end
        tests++; if (bus.pipe_hold !== 1'b0) begin fails++; $display("FAIL reset_hold: got %b want 0", bus.pipe_hold); end
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
        tests++; if (bus.ll_ready !== 1'b0) begin fails++; $display("FAIL reset_ll_ready: got %b want 0", bus.ll_ready); end
        tests++; if (bus.id_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus.id_stall); end
        rst = 0;
        idle();
        @(negedge clk);
    endtask

    task automatic test_pipe_write();
        bus.pipe_we = 1; bus.pipe_waddr = 5; bus.pipe_wdata = 32'h1234;
        bus.ll_valid = 1; bus.ll_waddr = 3; bus.ll_wdata = 32'hdead;
        #1;
        tests++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL pipe_rf_we: got %b want 1", bus.rf_we); end
        tests++; if (bus.rf_waddr !== 5'd5) begin fails++; $display("FAIL pipe_rf_waddr: got %0d want 5", bus.rf_waddr); end
        tests++; if (bus.rf_wdata !== 32'h1234) begin fails++; $display("FAIL pipe_rf_wdata: got %h want 1234", bus.rf_wdata); end
        tests++; if (bus.ll_ready !== 1'b0) begin fails++; $display("FAIL pipe_ll_ready: got %b want 0", bus.ll_ready); end
        @(negedge clk);
        idle();
        bus.pipe_we = 1; bus.pipe_waddr = 0; bus.pipe_wdata = 32'hbeef;
        #1;
        tests++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd0, 32'hbeef}) begin fails++; $display("FAIL r0_passthru: got %b/%0d/%h want 1/0/beef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(negedge clk);
        idle();
        #1;
        tests++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'h0}) begin fails++; $display("FAIL idle_port: got %b/%0d/%h want 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(negedge clk);
    endtask

    task automatic test_raw();
        bus.ll_issue = 1; bus.ll_issue_addr = 7;
        @(negedge clk);
        idle();
        bus.id_raddr1 = 7; bus.id_re1 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.id_stall !== 1'b1) begin fails++; $display("FAIL raw_stall_%0d: got %b want 1", i, bus.id_stall); end
            @(negedge clk);
        end
        bus.id_re1 = 0;
        #1;
        tests++; if (bus.id_stall !== 1'b0) begin fails++; $display("FAIL raw_re_off: got %b want 0", bus.id_stall); end
        bus.id_we = 1; bus.id_waddr = 7;
        #1;
        tests++; if (bus.id_stall !== 1'b1) begin fails++; $display("FAIL waw_stall: got %b want 1", bus.id_stall); end
        @(negedge clk);
        bus.id_we = 0; bus.id_re1 = 1;
        bus.ll_valid = 1; bus.ll_waddr = 7; bus.ll_wdata = 32'haa55;
        #1;
        tests++; if (bus.id_stall !== 1'b0) begin fails++; $display("FAIL retire_stall: got %b want 0", bus.id_stall); end
        tests++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'haa55}) begin fails++; $display("FAIL retire_write: got %b/%0d/%h want 1/7/aa55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(negedge clk);
        bus.ll_valid = 0;
        #1;
        tests++; if (dut.pending[7] !== 1'b0) begin fails++; $display("FAIL retire_pending: got %b want 0", dut.pending[7]); end
        tests++; if (bus.id_stall !== 1'b0) begin fails++; $display("FAIL after_retire_stall: got %b want 0", bus.id_stall); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_starvation(input bit drop);
        bus.pipe_we = 1; bus.pipe_waddr = 10; bus.pipe_wdata = 32'h55;
        bus.ll_valid = 1; bus.ll_waddr = 12; bus.ll_wdata = 32'h77;
        for (int c = 1; c <= 4; c++) begin
            #1;
            tests++; if ({bus.ll_ready, bus.pipe_hold, bus.rf_waddr} !== {1'b0, 1'b0, 5'd10}) begin fails++; $display("FAIL starve_c%0d: ready/hold/waddr got %b/%b/%0d want 0/0/10", c, bus.ll_ready, bus.pipe_hold, bus.rf_waddr); end
            @(negedge clk);
        end
        if (drop) bus.ll_valid = 0;
        #1;
        tests++; if (bus.pipe_hold !== 1'b1) begin fails++; $display("FAIL starve_hold: got %b want 1", bus.pipe_hold); end
        if (drop) begin
            tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL drop_rf_we: got %b want 0", bus.rf_we); end
        end else begin
            tests++; if ({bus.ll_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 1'b1, 5'd12, 32'h77}) begin fails++; $display("FAIL starve_ll_win: got %b/%b/%0d/%h want 1/1/12/77", bus.ll_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        end
        @(negedge clk);
        bus.ll_valid = 0;
        #1;
        tests++; if ({bus.pipe_hold, bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 1'b1, 5'd10, 32'h55}) begin fails++; $display("FAIL starve_c6: hold/we/waddr/wdata got %b/%b/%0d/%h want 0/1/10/55", bus.pipe_hold, bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reissue();
        bus.ll_issue = 1; bus.ll_issue_addr = 9;
        @(negedge clk);
        idle();
        bus.ll_valid = 1; bus.ll_waddr = 9; bus.ll_wdata = 32'h9;
        bus.ll_issue = 1; bus.ll_issue_addr = 9;
        bus.id_re2 = 1; bus.id_raddr2 = 9;
        #1;
        tests++; if ({bus.id_stall, bus.rf_we} !== 2'b01) begin fails++; $display("FAIL reissue_same_cycle: stall/we got %b/%b want 0/1", bus.id_stall, bus.rf_we); end
        @(negedge clk);
        bus.ll_valid = 0; bus.ll_issue = 0;
        #1;
        tests++; if (dut.pending[9] !== 1'b1) begin fails++; $display("FAIL reissue_pending: got %b want 1", dut.pending[9]); end
        tests++; if (bus.id_stall !== 1'b1) begin fails++; $display("FAIL reissue_stall: got %b want 1", bus.id_stall); end
        bus.ll_valid = 1; bus.ll_waddr = 9;
        @(negedge clk);
        idle();
        #1;
        tests++; if (dut.pending !== 32'h0) begin fails++; $display("FAIL reissue_clean: got %h want 0", dut.pending); end
        @(negedge clk);
    endtask

    task automatic test_addr0_reset();
        bus.ll_issue = 1; bus.ll_issue_addr = 0;
        bus.id_re1 = 1; bus.id_raddr1 = 0;
        #1;
        tests++; if (bus.id_stall !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b want 0", bus.id_stall); end
        @(negedge clk);
        idle();
        #1;
        tests++; if (dut.pending !== 32'h0) begin fails++; $display("FAIL r0_issue: got %h want 0", dut.pending); end
        bus.ll_issue = 1; bus.ll_issue_addr = 3;
        @(negedge clk);
        idle();
        bus.pipe_we = 1; bus.pipe_waddr = 1; bus.ll_valid = 1; bus.ll_waddr = 4;
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({dut.pending[3], dut.wait_cnt} !== {1'b1, 4'd2}) begin fails++; $display("FAIL pre_reset: pending3/wait got %b/%0d want 1/2", dut.pending[3], dut.wait_cnt); end
        rst = 1;
        #1;
        tests++; if ({bus.rf_we, bus.ll_ready} !== 2'b00) begin fails++; $display("FAIL in_reset_port: we/ready got %b/%b want 0/0", bus.rf_we, bus.ll_ready); end
        @(negedge clk);
        #1;
        tests++; if ({dut.pending, dut.wait_cnt, bus.pipe_hold} !== {32'h0, 4'd0, 1'b0}) begin fails++; $display("FAIL mid_reset: pending/wait/hold got %h/%0d/%b want 0/0/0", dut.pending, dut.wait_cnt, bus.pipe_hold); end
        rst = 0;
        idle();
        @(negedge clk);
    endtask

    initial begin
        idle();
        test_reset();
        test_pipe_write();
        test_raw();
        test_starvation(1'b0);
        test_starvation(1'b1);
        test_reissue();
        test_addr0_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
